simon_button_encoder: RTL and testbench

SIMON_BUTTON_ENCODER -- requirements
Module: simon_button_encoder

---
 rtl/simon_button_encoder_pkg.sv | 45 ++++
 rtl/simon_button_encoder_sync_2ff.sv | 30 +++
 rtl/simon_button_encoder.sv | 134 +++++++++++++
 tb/tb_simon_button_encoder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_button_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : simon_button_encoder_pkg
// Purpose  : Shared Simon constants: button codes, FSM states and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package simon_button_encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DB_PRESS   = 2'd1,
        ST_HELD       = 2'd2,
        ST_DB_RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] C_CODE_NONE = 4'd0;
    localparam logic [3:0] C_CODE_TL   = 4'd1;
    localparam logic [3:0] C_CODE_TR   = 4'd2;
    localparam logic [3:0] C_CODE_BL   = 4'd3;
    localparam logic [3:0] C_CODE_BR   = 4'd4;

    // Bit positions inside the synchronized button vector.
    localparam int C_IDX_TL = 3;
    localparam int C_IDX_TR = 2;
    localparam int C_IDX_BL = 1;
    localparam int C_IDX_BR = 0;

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [3:0] encode_button(input logic [3:0] v);
        logic [3:0] code;
        case (v)
            4'b1000: code = C_CODE_TL;
            4'b0100: code = C_CODE_TR;
            4'b0010: code = C_CODE_BL;
            4'b0001: code = C_CODE_BR;
            default: code = C_CODE_NONE;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/simon_button_encoder_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer for one asynchronous button input.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/simon_button_encoder.sv
`default_nettype none
// ============================================================================
// Module   : simon_button_encoder
// Purpose  : Debounces four quadrant buttons and hands one code per press.
// Revision : 1.0 - initial release
// ============================================================================
module simon_button_encoder
    import simon_button_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_tl,
    input  logic       btn_tr,
    input  logic       btn_bl,
    input  logic       btn_br,
    input  logic       accept_en,
    input  logic       button_ack,
    output logic [3:0] button,
    output logic       button_valid,
    output logic       busy
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       w_raw;
    logic [3:0]       w_sync;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_cand;
    logic [3:0]       w_cand_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_load;
    logic [3:0]       r_button;
    logic             r_valid;

    assign w_raw = {btn_tl, btn_tr, btn_bl, btn_br};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sync
            sync_2ff u_sync (
                .clk (clk),
                .rst (rst),
                .d   (w_raw[gi]),
                .q   (w_sync[gi])
            );
        end
    endgenerate

    assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : (r_cnt + C_CNT_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cand  <= 4'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A pending code blocks new presses; nothing is queued.
                if (is_one_hot(w_sync) && accept_en && !r_valid) begin
                    w_state_nxt = ST_DB_PRESS;
                    w_cand_nxt  = w_sync;
                    w_cnt_nxt   = '0;
                end
            end
            ST_DB_PRESS: begin
                if (w_sync != r_cand) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt >= C_CNT_LAST) begin
                    w_state_nxt = ST_HELD;
                    w_load      = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_HELD: begin
                if (w_sync == 4'd0) begin
                    w_state_nxt = ST_DB_RELEASE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_DB_RELEASE: begin
                if (w_sync != 4'd0) begin
                    w_state_nxt = ST_HELD;
                end else if (r_cnt >= C_CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Loading a fresh code takes priority over an acknowledge on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_button <= C_CODE_NONE;
            r_valid  <= 1'b0;
        end else if (w_load) begin
            r_button <= encode_button(r_cand);
            r_valid  <= 1'b1;
        end else if (button_ack && r_valid) begin
            r_button <= C_CODE_NONE;
            r_valid  <= 1'b0;
        end
    end

    assign button       = r_button;
    assign button_valid = r_valid;
    assign busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_simon_button_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_simon_button_encoder
// Purpose  : Directed and randomized self-checking bench with a run-length model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simon_button_encoder;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_tl = 1'b0;
    logic       btn_tr = 1'b0;
    logic       btn_bl = 1'b0;
    logic       btn_br = 1'b0;
    logic       accept_en = 1'b1;
    logic       button_ack = 1'b0;
    logic [3:0] button;
    logic       button_valid;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    simon_button_encoder #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_tl       (btn_tl),
        .btn_tr       (btn_tr),
        .btn_bl       (btn_bl),
        .btn_br       (btn_br),
        .accept_en    (accept_en),
        .button_ack   (button_ack),
        .button       (button),
        .button_valid (button_valid),
        .busy         (busy)
    );

    // Reference: two-sample delay line, then run-length counting of stable samples.
    logic [3:0] m_s1 = 4'd0;
    logic [3:0] m_s2 = 4'd0;
    logic [3:0] m_cand = 4'd0;
    logic [3:0] m_code = 4'd0;
    logic       m_valid = 1'b0;
    int         m_phase = 0;   // 0 waiting, 1 pressing, 2 held, 3 releasing
    int         m_run = 0;

    function automatic logic [3:0] code_of(input logic [3:0] v);
        for (int i = 0; i < 4; i++)
            if (v == (4'b1000 >> i)) return 4'(i + 1);
        return 4'd0;
    endfunction

    task automatic model_step();
        logic [3:0] sv;
        logic       load;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_cand = 0; m_code = 0; m_valid = 0;
            m_phase = 0; m_run = 0;
            return;
        end
        sv   = m_s2;
        load = 1'b0;
        if (m_phase == 0) begin
            if ($countones(sv) == 1 && accept_en && !m_valid) begin
                m_phase = 1; m_cand = sv; m_run = 1;
            end
        end else if (m_phase == 1) begin
            if (sv != m_cand) m_phase = 0;
            else begin
                m_run++;
                if (m_run == D + 1) begin m_phase = 2; load = 1'b1; end
            end
        end else if (m_phase == 2) begin
            if (sv == 0) begin m_phase = 3; m_run = 1; end
        end else begin
            if (sv != 0) m_phase = 2;
            else begin
                m_run++;
                if (m_run == D + 1) m_phase = 0;
            end
        end
        if (load) begin
            m_valid = 1'b1; m_code = code_of(m_cand);
        end else if (button_ack && m_valid) begin
            m_valid = 1'b0; m_code = 0;
        end
        m_s2 = m_s1;
        m_s1 = {btn_tl, btn_tr, btn_bl, btn_br};
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            check("model", {26'd0, button, button_valid, busy},
                  {26'd0, m_code, m_valid, (m_phase != 0)});
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_valid(output int e);
        e = 0;
        while (button_valid !== 1'b1 && e < 40) begin
            @(posedge clk); #1; e++;
        end
    endtask

    task automatic ack_once();
        button_ack = 1'b1; step(1); button_ack = 1'b0;
    endtask

    int         e;
    int         r;
    int         hold;
    logic [3:0] p;

    initial begin
        fork compare_loop(); join_none
        @(posedge clk); #1;
        step(2);
        rst = 1'b0;
        check("rst_button", button, 0);
        check("rst_valid", button_valid, 0);
        check("rst_busy", busy, 0);

        // Clean TR press, then acknowledge.
        btn_tr = 1; wait_valid(e);
        check("tr_latency", e, 7);
        check("tr_code", button, 2);
        ack_once();
        check("tr_ack_valid", button_valid, 0);
        check("tr_ack_code", button, 0);
        step(12); btn_tr = 0; step(12);
        check("tr_idle_busy", busy, 0);

        // Bouncing BL press.
        btn_bl = 1; step(1); btn_bl = 0; step(1); btn_bl = 1; step(1); btn_bl = 0; step(1);
        btn_bl = 1; wait_valid(e);
        check("bl_latency", e, 7);
        check("bl_code", button, 3);
        ack_once(); step(10);
        check("bl_single_code", button_valid, 0);
        btn_bl = 0; step(12);

        // TL and BR together.
        btn_tl = 1; btn_br = 1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("multi_busy", busy, 0);
            check("multi_valid", button_valid, 0);
        end
        btn_tl = 0; btn_br = 0; step(4);
        check("multi_end_busy", busy, 0);

        // Pending TL code blocks a later BR press.
        btn_tl = 1; wait_valid(e);
        check("tl_latency", e, 7);
        check("tl_code", button, 1);
        step(5); btn_tl = 0; step(12); btn_br = 1; step(12);
        check("tl_held_code", button, 1);
        check("tl_held_valid", button_valid, 1);
        check("br_ignored_busy", busy, 0);
        btn_br = 0; step(4); ack_once();
        check("tl_ack_valid", button_valid, 0);
        btn_br = 1; wait_valid(e);
        check("br_latency", e, 7);
        check("br_code", button, 4);
        ack_once(); btn_br = 0; step(12);

        // Asynchronous reset during DB_PRESS and with a pending code.
        btn_tr = 1; step(4);
        check("rst1_pre_busy", busy, 1);
        #2 rst = 1; #1;
        check("rst1_busy", busy, 0);
        check("rst1_valid", button_valid, 0);
        @(posedge clk); #1; rst = 0;
        wait_valid(e);
        check("rst1_latency", e, 7);
        check("rst1_code", button, 2);
        #2 rst = 1; #1;
        check("rst2_valid", button_valid, 0);
        check("rst2_button", button, 0);
        check("rst2_busy", busy, 0);
        @(posedge clk); #1; rst = 0;
        wait_valid(e);
        check("rst2_latency", e, 7);
        check("rst2_code", button, 2);
        ack_once(); btn_tr = 0; step(12);

        // accept_en low during a press, raised while still held.
        accept_en = 0; btn_tr = 1; step(10);
        check("gate_valid", button_valid, 0);
        check("gate_busy", busy, 0);
        accept_en = 1; wait_valid(e);
        check("gate_latency", e, 5);
        check("gate_code", button, 2);
        ack_once(); btn_tr = 0; step(12);

        // Randomized traffic.
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                r = $urandom_range(0, 9);
                if (r < 6)      p = 4'b0001 << $urandom_range(0, 3);
                else if (r < 8) p = 4'd0;
                else            p = 4'($urandom_range(0, 15));
                {btn_tl, btn_tr, btn_bl, btn_br} = p;
                hold = $urandom_range(1, 12);
            end else begin
                hold--;
            end
            accept_en  = ($urandom_range(0, 7) != 0);
            button_ack = ($urandom_range(0, 5) == 0);
            rst        = ($urandom_range(0, 299) == 0);
            step(1);
        end
        {btn_tl, btn_tr, btn_bl, btn_br} = 4'd0;
        button_ack = 0; rst = 0; accept_en = 1;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
